// File: rtl/pic_host_pkg.sv
// rtl/pic_host_pkg.sv - shared types and constants for the 8259A-style PIC host master
// Purpose: FSM state enum, bus-cycle kinds and phases, OCW2 EOI encodings, ICW1 steering bit indices.
// Ports: none (package).
package pic_host_pkg;

    typedef enum logic [3:0] {
        S_INIT, S_ICW1, S_ICW2, S_ICW3, S_ICW4, S_OCW1,
        S_IDLE, S_INTA, S_EOI, S_ACC, S_AEOI
    } host_state_e;

    typedef enum logic [1:0] {CYC_WR, CYC_RD, CYC_INTA} cyc_kind_e;

    typedef enum logic [2:0] {P_IDLE, P_SETUP, P_LOW, P_GAP, P_LOW2, P_HOLD} bus_phase_e;

    localparam logic [7:0] EOI_NONSPEC   = 8'h20;
    localparam logic [7:0] EOI_SPEC_BASE = 8'h60;

    localparam int ICW1_SNGL_BIT = 1;
    localparam int ICW1_IC4_BIT  = 0;

    function automatic logic [7:0] ocw2_eoi(input logic specific, input logic [2:0] level);
        return specific ? (EOI_SPEC_BASE | {5'b00000, level}) : EOI_NONSPEC;
    endfunction

endpackage

// File: rtl/pic_bus_cycle.sv
// rtl/pic_bus_cycle.sv - strobe timing engine for PIC write, read and two-pulse INTA cycles
// Purpose: on start, runs one bus cycle of the requested kind and drives registered strobes.
//   WR/RD: SETUP (cs_n low) -> strobe low PULSE_CYC -> HOLD (cs_n low, strobe high).
//   INTA : inta_n low PULSE_CYC -> high GAP_CYC -> low PULSE_CYC -> REC; cs_n stays high.
// Ports: clk, rst_n (async active-low); start, kind, req_a0, req_data (cycle request);
//   cs_n, wr_n, rd_n, inta_n, a0, data_out (bus); last_low (final low clock of the
//   data-carrying strobe), sample (last_low for RD/INTA), done (HOLD/REC clock).
import pic_host_pkg::*;

module pic_bus_cycle #(
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  cyc_kind_e  kind,
    input  logic       req_a0,
    input  logic [7:0] req_data,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       inta_n,
    output logic       a0,
    output logic [7:0] data_out,
    output logic       last_low,
    output logic       sample,
    output logic       done
);

    bus_phase_e phase;
    cyc_kind_e  kind_q;
    logic [7:0] cnt;

    wire pulse_end = (cnt == 8'(PULSE_CYC - 1));
    wire gap_end   = (cnt == 8'(GAP_CYC - 1));

    // For INTA only the second pulse carries the vector, so the first low phase never counts.
    assign last_low = pulse_end && ((phase == P_LOW && kind_q != CYC_INTA) || phase == P_LOW2);
    assign sample   = last_low && (kind_q != CYC_WR);
    assign done     = (phase == P_HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= P_IDLE;
            kind_q   <= CYC_WR;
            cnt      <= 8'd0;
            cs_n     <= 1'b1;
            wr_n     <= 1'b1;
            rd_n     <= 1'b1;
            inta_n   <= 1'b1;
            a0       <= 1'b0;
            data_out <= 8'd0;
        end else if (start) begin
            kind_q <= kind;
            cnt    <= 8'd0;
            wr_n   <= 1'b1;
            rd_n   <= 1'b1;
            if (kind == CYC_INTA) begin
                phase  <= P_LOW;
                cs_n   <= 1'b1;
                inta_n <= 1'b0;
            end else begin
                phase    <= P_SETUP;
                cs_n     <= 1'b0;
                inta_n   <= 1'b1;
                a0       <= req_a0;
                data_out <= req_data;
            end
        end else begin
            case (phase)
                P_SETUP: begin
                    phase <= P_LOW;
                    cnt   <= 8'd0;
                    wr_n  <= (kind_q != CYC_WR);
                    rd_n  <= (kind_q != CYC_RD);
                end
                P_LOW: begin
                    if (pulse_end) begin
                        cnt <= 8'd0;
                        if (kind_q == CYC_INTA) begin
                            phase  <= P_GAP;
                            inta_n <= 1'b1;
                        end else begin
                            phase <= P_HOLD;
                            wr_n  <= 1'b1;
                            rd_n  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                P_GAP: begin
                    if (gap_end) begin
                        phase  <= P_LOW2;
                        cnt    <= 8'd0;
                        inta_n <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                P_LOW2: begin
                    if (pulse_end) begin
                        phase  <= P_HOLD;
                        cnt    <= 8'd0;
                        inta_n <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                P_HOLD: begin
                    phase <= P_IDLE;
                    cs_n  <= 1'b1;
                end
                default: phase <= P_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pic_host_master.sv
// rtl/pic_host_master.sv - CPU-side initiator for an 8259A-style PIC
// Purpose: programs ICW1..ICW4 + OCW1 after reset, serves INT with a two-pulse INTA cycle and
//   captures the vector, issues OCW2 EOI writes and generic host register reads/writes.
//   Arbitration in IDLE: INTA > EOI > host access. New INTA is held off while a vector is pending.
// Optional feature macro: PIC_HOST_AUTO_EOI_EN - after each vector handshake a non-specific EOI
//   is written before any other IDLE arbitration, without an eoi_ack pulse.
// Ports: clk, rst_n (async active-low); int_in; cs_n, wr_n, rd_n, inta_n, a0, data_out, data_in
//   (PIC bus); init_done; irq_enable; vector/vector_valid/vector_ready; eoi_req/eoi_specific/
//   eoi_level/eoi_ack; acc_req/acc_wr/acc_a0/acc_wdata/acc_rdata/acc_done.
import pic_host_pkg::*;

module pic_host_master #(
    parameter int         PULSE_CYC = 2,
    parameter int         GAP_CYC   = 1,
    parameter logic [7:0] ICW1_VAL  = 8'h13,
    parameter logic [7:0] ICW2_VAL  = 8'h20,
    parameter logic [7:0] ICW3_VAL  = 8'h00,
    parameter logic [7:0] ICW4_VAL  = 8'h01,
    parameter logic [7:0] OCW1_INIT = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       int_in,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       inta_n,
    output logic       a0,
    output logic [7:0] data_out,
    input  logic [7:0] data_in,
    output logic       init_done,
    input  logic       irq_enable,
    output logic [7:0] vector,
    output logic       vector_valid,
    input  logic       vector_ready,
    input  logic       eoi_req,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    output logic       eoi_ack,
    input  logic       acc_req,
    input  logic       acc_wr,
    input  logic       acc_a0,
    input  logic [7:0] acc_wdata,
    output logic [7:0] acc_rdata,
    output logic       acc_done
);

    host_state_e state;
    logic        int_s1, int_s2;
    logic        cyc_start, cyc_a0;
    cyc_kind_e   cyc_kind;
    logic [7:0]  cyc_data;
    logic        cyc_last_low, cyc_sample, cyc_done;
`ifdef PIC_HOST_AUTO_EOI_EN
    logic        aeoi_pend;
`endif

    pic_bus_cycle #(.PULSE_CYC(PULSE_CYC), .GAP_CYC(GAP_CYC)) u_cycle (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (cyc_start),
        .kind     (cyc_kind),
        .req_a0   (cyc_a0),
        .req_data (cyc_data),
        .cs_n     (cs_n),
        .wr_n     (wr_n),
        .rd_n     (rd_n),
        .inta_n   (inta_n),
        .a0       (a0),
        .data_out (data_out),
        .last_low (cyc_last_low),
        .sample   (cyc_sample),
        .done     (cyc_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_s1 <= 1'b0;
            int_s2 <= 1'b0;
        end else begin
            int_s1 <= int_in;
            int_s2 <= int_s1;
        end
    end

    // Each bus state launches its cycle on entry (cyc_start pulse) and moves on in the HOLD/REC clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_INIT;
            cyc_start    <= 1'b0;
            cyc_kind     <= CYC_WR;
            cyc_a0       <= 1'b0;
            cyc_data     <= 8'd0;
            init_done    <= 1'b0;
            vector       <= 8'd0;
            vector_valid <= 1'b0;
            eoi_ack      <= 1'b0;
            acc_rdata    <= 8'd0;
            acc_done     <= 1'b0;
`ifdef PIC_HOST_AUTO_EOI_EN
            aeoi_pend    <= 1'b0;
`endif
        end else begin
            cyc_start <= 1'b0;
            eoi_ack   <= 1'b0;
            acc_done  <= 1'b0;

            if (vector_valid && vector_ready) begin
                vector_valid <= 1'b0;
                vector       <= 8'd0;
`ifdef PIC_HOST_AUTO_EOI_EN
                aeoi_pend    <= 1'b1;
`endif
            end

            case (state)
                S_INIT: begin
                    state     <= S_ICW1;
                    cyc_start <= 1'b1;
                    cyc_kind  <= CYC_WR;
                    cyc_a0    <= 1'b0;
                    cyc_data  <= ICW1_VAL;
                end
                S_ICW1: if (cyc_done) begin
                    state     <= S_ICW2;
                    cyc_start <= 1'b1;
                    cyc_a0    <= 1'b1;
                    cyc_data  <= ICW2_VAL;
                end
                S_ICW2: if (cyc_done) begin
                    cyc_start <= 1'b1;
                    if (!ICW1_VAL[ICW1_SNGL_BIT]) begin
                        state    <= S_ICW3;
                        cyc_data <= ICW3_VAL;
                    end else if (ICW1_VAL[ICW1_IC4_BIT]) begin
                        state    <= S_ICW4;
                        cyc_data <= ICW4_VAL;
                    end else begin
                        state    <= S_OCW1;
                        cyc_data <= OCW1_INIT;
                    end
                end
                S_ICW3: if (cyc_done) begin
                    cyc_start <= 1'b1;
                    if (ICW1_VAL[ICW1_IC4_BIT]) begin
                        state    <= S_ICW4;
                        cyc_data <= ICW4_VAL;
                    end else begin
                        state    <= S_OCW1;
                        cyc_data <= OCW1_INIT;
                    end
                end
                S_ICW4: if (cyc_done) begin
                    state     <= S_OCW1;
                    cyc_start <= 1'b1;
                    cyc_data  <= OCW1_INIT;
                end
                S_OCW1: if (cyc_done) begin
                    state     <= S_IDLE;
                    init_done <= 1'b1;
                end
                S_IDLE: begin
`ifdef PIC_HOST_AUTO_EOI_EN
                    // A handshake in this very clock also counts, so nothing can slip in ahead of the auto EOI.
                    if (aeoi_pend || (vector_valid && vector_ready)) begin
                        aeoi_pend <= 1'b0;
                        state     <= S_AEOI;
                        cyc_start <= 1'b1;
                        cyc_kind  <= CYC_WR;
                        cyc_a0    <= 1'b0;
                        cyc_data  <= EOI_NONSPEC;
                    end else
`endif
                    if (int_s2 && irq_enable && !vector_valid) begin
                        state     <= S_INTA;
                        cyc_start <= 1'b1;
                        cyc_kind  <= CYC_INTA;
                    end else if (eoi_req) begin
                        state     <= S_EOI;
                        cyc_start <= 1'b1;
                        cyc_kind  <= CYC_WR;
                        cyc_a0    <= 1'b0;
                        cyc_data  <= ocw2_eoi(eoi_specific, eoi_level);
                    end else if (acc_req) begin
                        state     <= S_ACC;
                        cyc_start <= 1'b1;
                        cyc_kind  <= acc_wr ? CYC_WR : CYC_RD;
                        cyc_a0    <= acc_a0;
                        cyc_data  <= acc_wdata;
                    end
                end
                S_INTA: begin
                    // The vector is passed through as-is, including a spurious one if INT dropped mid-cycle.
                    if (cyc_sample) vector <= data_in;
                    if (cyc_done) begin
                        vector_valid <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                S_EOI: begin
                    if (cyc_last_low) eoi_ack <= 1'b1;
                    if (cyc_done) state <= S_IDLE;
                end
                S_ACC: begin
                    if (cyc_sample) acc_rdata <= data_in;
                    if (cyc_last_low) acc_done <= 1'b1;
                    if (cyc_done) state <= S_IDLE;
                end
                S_AEOI: if (cyc_done) state <= S_IDLE;
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_pic_host_master.sv
// tb/tb_pic_host_master.sv - scoreboard bench for pic_host_master (default and ICW3-enabled builds)
module tb_pic_host_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b1, rst2_n = 1'b1;
    logic       int_in = 1'b0, irq_enable = 1'b0, vector_ready = 1'b0;
    logic       eoi_req = 1'b0, eoi_specific = 1'b0;
    logic [2:0] eoi_level = 3'd0;
    logic       acc_req = 1'b0, acc_wr = 1'b0, acc_a0 = 1'b0;
    logic [7:0] acc_wdata = 8'd0;
    logic [7:0] vec_val = 8'h23, reg_val = 8'h5A;

    logic       cs_n, wr_n, rd_n, inta_n, a0, init_done, vector_valid, eoi_ack, acc_done;
    logic [7:0] data_out, vector, acc_rdata, data_in;
    logic       cs2_n, wr2_n, rd2_n, inta2_n, a02, init_done2, vv2, eoi_ack2, acc_done2;
    logic [7:0] data_out2, vector2, acc_rdata2;

    // PIC model: vector while INTA is low, register contents otherwise.
    assign data_in = inta_n ? reg_val : vec_val;

    pic_host_master dut (
        .clk(clk), .rst_n(rst_n), .int_in(int_in), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n),
        .inta_n(inta_n), .a0(a0), .data_out(data_out), .data_in(data_in), .init_done(init_done),
        .irq_enable(irq_enable), .vector(vector), .vector_valid(vector_valid),
        .vector_ready(vector_ready), .eoi_req(eoi_req), .eoi_specific(eoi_specific),
        .eoi_level(eoi_level), .eoi_ack(eoi_ack), .acc_req(acc_req), .acc_wr(acc_wr),
        .acc_a0(acc_a0), .acc_wdata(acc_wdata), .acc_rdata(acc_rdata), .acc_done(acc_done)
    );

    pic_host_master #(.ICW1_VAL(8'h11)) dut2 (
        .clk(clk), .rst_n(rst2_n), .int_in(1'b0), .cs_n(cs2_n), .wr_n(wr2_n), .rd_n(rd2_n),
        .inta_n(inta2_n), .a0(a02), .data_out(data_out2), .data_in(8'h00), .init_done(init_done2),
        .irq_enable(1'b0), .vector(vector2), .vector_valid(vv2), .vector_ready(1'b0),
        .eoi_req(1'b0), .eoi_specific(1'b0), .eoi_level(3'd0), .eoi_ack(eoi_ack2),
        .acc_req(1'b0), .acc_wr(1'b0), .acc_a0(1'b0), .acc_wdata(8'h00), .acc_rdata(acc_rdata2),
        .acc_done(acc_done2)
    );

    localparam int K_WR = 0, K_RD = 1, K_INTA = 2;
    typedef struct {int kind; int a0; int data;} txn_t;
    txn_t exp_bus[$], exp_bus2[$];
    int   exp_vec[$], exp_acc[$];   // exp_acc: -1 for a write, else expected read data
    int   n_cmp = 0, n_fail = 0;
    int   n_wr2 = 0;
    time  last_wr_t = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic push(input int k, input int a, input int d);
        txn_t t;
        t.kind = k; t.a0 = a; t.data = d;
        exp_bus.push_back(t);
    endtask

    task automatic push2(input int a, input int d);
        txn_t t;
        t.kind = K_WR; t.a0 = a; t.data = d;
        exp_bus2.push_back(t);
    endtask

    task automatic pop_check(input string nm, input int act, input int kind, input int extra);
        txn_t t;
        if (exp_bus.size() == 0) begin
            chk({nm, "_unexpected"}, act, -1);
        end else begin
            t = exp_bus.pop_front();
            chk(nm, act, (kind << 24) | extra | ((kind == K_WR) ? ((t.a0 << 8) | t.data) :
                                                   (kind == K_RD) ? (t.a0 << 8) : 0) | (t.kind << 28));
        end
    endtask

    // Monitor for the default-build DUT.
    int  wr_low, rd_low, i_low, low1, gap, ipulse, cs_bad;
    logic pw = 1'b1, pr = 1'b1, pi = 1'b1, pvv = 1'b0;
    int  cap_a0, cap_d;
    always @(negedge clk) begin
        if (!rst_n) begin
            wr_low = 0; rd_low = 0; i_low = 0; low1 = 0; gap = 0; ipulse = 0; cs_bad = 0;
            pw = 1'b1; pr = 1'b1; pi = 1'b1; pvv = 1'b0;
        end else begin
            if (!wr_n) begin wr_low++; cap_a0 = int'(a0); cap_d = int'(data_out); end
            if (!rd_n) begin rd_low++; cap_a0 = int'(a0); end
            if (!inta_n) begin i_low++; if (!cs_n) cs_bad = 1; end
            if (!pw && wr_n) begin
                pop_check("wr_cycle", (K_WR << 28) | (K_WR << 24) | (int'(cs_n) << 20) | (wr_low << 16)
                          | (cap_a0 << 8) | cap_d, K_WR, 2 << 16);
                last_wr_t = $time;
                wr_low = 0;
            end
            if (!pr && rd_n) begin
                pop_check("rd_cycle", (K_RD << 28) | (K_RD << 24) | (int'(cs_n) << 20) | (rd_low << 16)
                          | (cap_a0 << 8), K_RD, 2 << 16);
                rd_low = 0;
            end
            if (!pi && inta_n) begin
                ipulse++;
                if (ipulse == 1) begin
                    low1 = i_low;
                end else begin
                    pop_check("inta_cycle", (K_INTA << 28) | (K_INTA << 24) | (low1 << 16) | (i_low << 8)
                              | (gap << 4) | cs_bad, K_INTA, (2 << 16) | (2 << 8) | (1 << 4));
                    ipulse = 0; gap = 0; cs_bad = 0;
                end
                i_low = 0;
            end
            if (inta_n && ipulse == 1) gap++;
            if (vector_valid && !pvv) begin
                if (exp_vec.size() == 0) chk("vector_unexpected", int'(vector), -1);
                else chk("vector", int'(vector), exp_vec.pop_front());
            end
            if (acc_done) begin
                if (exp_acc.size() == 0) chk("acc_unexpected", int'(acc_rdata), -1);
                else begin
                    int e;
                    e = exp_acc.pop_front();
                    if (e >= 0) chk("acc_rdata", int'(acc_rdata), e);
                end
            end
            pw = wr_n; pr = rd_n; pi = inta_n; pvv = vector_valid;
        end
    end

    // Monitor for the ICW3-enabled DUT (writes only).
    int   wr2_low = 0;
    logic pw2 = 1'b1;
    int   c2_a0, c2_d;
    always @(negedge clk) begin
        if (rst2_n) begin
            if (!wr2_n) begin wr2_low++; c2_a0 = int'(a02); c2_d = int'(data_out2); end
            if (!pw2 && wr2_n) begin
                if (exp_bus2.size() == 0) chk("wr2_unexpected", c2_d, -1);
                else begin
                    txn_t t;
                    t = exp_bus2.pop_front();
                    chk("wr2_cycle", (wr2_low << 16) | (c2_a0 << 8) | c2_d, (2 << 16) | (t.a0 << 8) | t.data);
                end
                n_wr2++;
                wr2_low = 0;
            end
            pw2 = wr2_n;
        end
    end

    task automatic wait_for(input int which, input int budget, input string nm);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            case (which)
                0: got = init_done;
                1: got = vector_valid;
                2: got = eoi_ack;
                3: got = acc_done;
                4: got = init_done2;
                default: got = !wr_n;
            endcase
        end
        chk(nm, int'(got), 1);
    endtask

    task automatic push_icw_default();
        push(K_WR, 0, 8'h13); push(K_WR, 1, 8'h20); push(K_WR, 1, 8'h01); push(K_WR, 1, 8'h00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nf;
        logic pin;
        rst_n = 1'b0; rst2_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({cs_n, wr_n, rd_n, inta_n, a0, data_out, init_done, vector_valid,
                                   vector, eoi_ack, acc_done, acc_rdata}),
            int'({4'b1111, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00}));

        // Init sequences; INT already pending during INIT must be served after IDLE entry.
        push_icw_default();
        push(K_INTA, 0, 0); exp_vec.push_back(8'h23);
        push2(0, 8'h11); push2(1, 8'h20); push2(1, 8'h00); push2(1, 8'h01); push2(1, 8'h00);
        int_in = 1'b1; irq_enable = 1'b1;
        rst_n = 1'b1; rst2_n = 1'b1;
        wait_for(0, 100, "init_done_wait");
        chk("init_done_one_clk_after_hold", int'($time - last_wr_t), 10);
        wait_for(4, 100, "init_done2_wait");
        chk("dut2_write_count", n_wr2, 5);

        // Vector held without ready, cleared after handshake.
        wait_for(1, 100, "vector_valid_wait");
        int_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("vector_held", int'({vector_valid, vector}), int'({1'b1, 8'h23}));
        end
        vector_ready = 1'b1;
        @(negedge clk);
        vector_ready = 1'b0;
        chk("vector_cleared", int'({vector_valid, vector}), 0);

        // Specific then non-specific EOI.
        push(K_WR, 0, 8'h63);
        eoi_specific = 1'b1; eoi_level = 3'd3; eoi_req = 1'b1;
        wait_for(2, 100, "eoi_ack_spec_wait");
        chk("eoi_ack_in_hold", int'({cs_n, wr_n}), 1);
        eoi_req = 1'b0;
        @(negedge clk);
        chk("eoi_ack_width", int'(eoi_ack), 0);
        push(K_WR, 0, 8'h20);
        eoi_specific = 1'b0; eoi_req = 1'b1;
        wait_for(2, 100, "eoi_ack_nonspec_wait");
        eoi_req = 1'b0;

        // Arbitration: INT, EOI and a read all pending when the access write finishes.
        push(K_WR, 1, 8'hA5); exp_acc.push_back(-1);
        acc_req = 1'b1; acc_wr = 1'b1; acc_a0 = 1'b1; acc_wdata = 8'hA5;
        wait_for(5, 100, "acc_write_strobe_wait");
        int_in = 1'b1; eoi_req = 1'b1; eoi_specific = 1'b0;
        push(K_INTA, 0, 0); exp_vec.push_back(8'h23);
        push(K_WR, 0, 8'h20);
        push(K_RD, 1, 0); exp_acc.push_back(8'h5A);
        wait_for(3, 100, "acc_write_done_wait");
        acc_wr = 1'b0;
        wait_for(1, 100, "arb_vector_wait");
        int_in = 1'b0;
        wait_for(2, 100, "arb_eoi_wait");
        eoi_req = 1'b0;
        wait_for(3, 100, "arb_read_done_wait");
        acc_req = 1'b0;
        vector_ready = 1'b1;
        @(negedge clk);
        vector_ready = 1'b0;

        // Reset in the middle of INTA2.
        vec_val = 8'h27;
        push(K_INTA, 0, 0); exp_vec.push_back(8'h27);
        int_in = 1'b1;
        nf = 0; pin = inta_n;
        for (int i = 0; i < 100 && nf < 2; i++) begin
            @(negedge clk);
            if (pin && !inta_n) nf++;
            pin = inta_n;
        end
        chk("inta2_reached", nf, 2);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_inta", int'({cs_n, wr_n, rd_n, inta_n, vector_valid}), int'(5'b11110));
        exp_bus.delete(); exp_vec.delete();
        int_in = 1'b0;
        repeat (2) @(negedge clk);
        push_icw_default();
        rst_n = 1'b1;
        wait_for(0, 100, "reinit_done_wait");
        repeat (4) @(negedge clk);

        chk("bus_queue_drained", exp_bus.size(), 0);
        chk("bus2_queue_drained", exp_bus2.size(), 0);
        chk("vector_queue_drained", exp_vec.size(), 0);
        chk("acc_queue_drained", exp_acc.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
